// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
// Contents: state_t (scanner FSM states), ROWS_RESET (row drive after reset),
//           key_map (row/column index to hex key code).
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // Row 0 driven low first; rows are active-low with exactly one bit low.
  localparam logic [3:0] ROWS_RESET = 4'b1110;

  // Row-major keypad legend:
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
  function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    code = 4'h0;
    case ({row_idx, col_idx})
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = 4'hC;
      4'd12: code = 4'hE;
      4'd13: code = 4'h0;
      4'd14: code = 4'hF;
      4'd15: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none; samples every cycle.
// Ports: clk, reset (async active-low), d_i [WIDTH] async input,
//        q_o [WIDTH] synchronized output (RST_VAL while in reset).
module sync_2ff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sense, press/release debounce, hex decode.
// Latency: key_valid one cycle after DEBOUNCE_CYCLES stable-low cycles following the row sample.
// Backpressure: none; key_valid is a single-cycle pulse with no ready.
// Ports: clk, reset (async active-low); rows[3:0] active-low row drive;
//        cols[3:0] active-low async column sense; key_valid pulse; key_code last key;
//        new_digit / old_digit last two accepted keys (feed display s1 / s2).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV        = 16'd5000,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd120000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] rows,
  input  logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] new_digit,
  output logic [3:0] old_digit
);

  logic [3:0]  cols_s;

  state_t      state_q,     state_d;
  logic [3:0]  rows_q,      rows_d;
  logic [15:0] scan_cnt_q,  scan_cnt_d;
  logic [19:0] deb_cnt_q,   deb_cnt_d;
  logic [1:0]  row_sel_q,   row_sel_d;
  logic [1:0]  col_sel_q,   col_sel_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_code_q,  key_code_d;
  logic [3:0]  new_q,       new_d;
  logic [3:0]  old_q,       old_d;

  logic [1:0]  row_idx;
  logic [1:0]  low_col;
  logic [3:0]  rows_next;
  logic        col_low;

  // Idle columns float high, so the synchronizer resets to "no key".
  sync_2ff #(
    .WIDTH   (4),
    .RST_VAL (4'hF)
  ) u_cols_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (cols),
    .q_o   (cols_s)
  );

  // Index of the row currently driven low.
  always_comb begin
    row_idx = 2'd0;
    case (rows_q)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // Lowest-index active column wins when several keys share a row.
  always_comb begin
    low_col = 2'd3;
    casez (cols_s)
      4'b???0: low_col = 2'd0;
      4'b??01: low_col = 2'd1;
      4'b?011: low_col = 2'd2;
      default: low_col = 2'd3;
    endcase
  end

  assign rows_next = {rows_q[2:0], rows_q[3]};
  // Only the latched column matters once a key is being tracked.
  assign col_low   = ~cols_s[col_sel_q];

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    scan_cnt_d  = scan_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    row_sel_d   = row_sel_q;
    col_sel_d   = col_sel_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    new_d       = new_q;
    old_d       = old_q;

    case (state_q)
      SCAN: begin
        // Sampling only at the end of the row window leaves SCAN_DIV cycles
        // for the row to settle and pass through the synchronizer.
        if (scan_cnt_q == SCAN_DIV - 16'd1) begin
          scan_cnt_d = 16'd0;
          if (cols_s != 4'hF) begin
            row_sel_d = row_idx;
            col_sel_d = low_col;
            deb_cnt_d = 20'd0;
            state_d   = DEB_PRESS;
          end else begin
            rows_d = rows_next;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 16'd1;
        end
      end

      DEB_PRESS: begin
        if (!col_low) begin
          // Bounce: abandon the candidate and carry on with the next row.
          state_d    = SCAN;
          rows_d     = rows_next;
          scan_cnt_d = 16'd0;
          deb_cnt_d  = 20'd0;
        end else if (deb_cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
          key_valid_d = 1'b1;
          key_code_d  = key_map(row_sel_q, col_sel_q);
          old_d       = new_q;
          new_d       = key_map(row_sel_q, col_sel_q);
          deb_cnt_d   = 20'd0;
          state_d     = HELD;
        end else begin
          deb_cnt_d = deb_cnt_q + 20'd1;
        end
      end

      HELD: begin
        if (!col_low) begin
          deb_cnt_d = 20'd0;
          state_d   = DEB_RELEASE;
        end
      end

      DEB_RELEASE: begin
        if (col_low) begin
          // Release bounce: the key is still down, no new event.
          deb_cnt_d = 20'd0;
          state_d   = HELD;
        end else if (deb_cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
          state_d    = SCAN;
          rows_d     = rows_next;
          scan_cnt_d = 16'd0;
          deb_cnt_d  = 20'd0;
        end else begin
          deb_cnt_d = deb_cnt_q + 20'd1;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      rows_q      <= ROWS_RESET;
      scan_cnt_q  <= 16'd0;
      deb_cnt_q   <= 20'd0;
      row_sel_q   <= 2'd0;
      col_sel_q   <= 2'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      new_q       <= 4'h0;
      old_q       <= 4'h0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      scan_cnt_q  <= scan_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      row_sel_q   <= row_sel_d;
      col_sel_q   <= col_sel_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      new_q       <= new_d;
      old_q       <= old_d;
    end
  end

  assign rows      = rows_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign new_digit = new_q;
  assign old_digit = old_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, scoreboard of expected key events.
// Latency: n/a. Backpressure: n/a.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DEB = 8;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] new_digit;
  logic [3:0] old_digit;

  keypad_scanner #(
    .SCAN_DIV        (16'(SD)),
    .DEBOUNCE_CYCLES (20'(DEB))
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_valid (key_valid),
    .key_code  (key_code),
    .new_digit (new_digit),
    .old_digit (old_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed-key matrix, index r*4+c.
  logic [15:0] pressed;

  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && pressed[r*4+c]) cols[c] = 1'b0;
  end

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] nd;
    logic [3:0] od;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] kmap [16];
  logic [3:0] model_new;
  int         checks;
  int         errors;
  int         pulses;
  time        last_pulse_t;
  logic       kv_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rows_eq(input logic [3:0] val, input int budget, input string name);
    int n;
    n = 0;
    while (rows !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(rows), 32'(val));
  endtask

  task automatic wait_rows_ne(input logic [3:0] val, input int budget, input string name);
    int n;
    n = 0;
    while (rows === val && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(rows !== val), 32'd1);
  endtask

  // A press that the model says will be accepted.
  task automatic expect_key(input int k);
    exp_t e;
    e.code = kmap[k];
    e.nd   = kmap[k];
    e.od   = model_new;
    exp_q.push_back(e);
    model_new = kmap[k];
  endtask

  // Monitor: every key_valid pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (key_valid) begin
      exp_t e;
      pulses++;
      last_pulse_t = $time;
      chk("kv_not_back_to_back", 32'(kv_prev), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("key_code", 32'(key_code), 32'(e.code));
        chk("new_digit", 32'(new_digit), 32'(e.nd));
        chk("old_digit", 32'(old_digit), 32'(e.od));
      end
    end
    kv_prev = key_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  p0;
    time t_final;
    kmap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    checks = 0; errors = 0; pulses = 0; last_pulse_t = 0; kv_prev = 1'b0;
    model_new = 4'h0;
    pressed = 16'h0;
    reset = 1'b0;
    cyc(3);
    chk("rst_rows", 32'(rows), 32'hE);
    chk("rst_kv", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_new", 32'(new_digit), 32'd0);
    chk("rst_old", 32'(old_digit), 32'd0);
    reset = 1'b1;

    // Idle rotation: row k/SD after k rising edges.
    for (int k = 0; k < 20; k++) begin
      chk("idle_rows", 32'(rows), 32'(~(4'b0001 << ((k / SD) % 4)) & 4'hF));
      @(negedge clk);
    end
    chk("idle_new", 32'(new_digit), 32'd0);
    chk("idle_old", 32'(old_digit), 32'd0);

    // Clean press (1,2), resume on row 2 after release.
    expect_key(6);
    pressed[6] = 1'b1;
    cyc(40);
    chk("held_rows_frozen", 32'(rows), 32'hD);
    pressed[6] = 1'b0;
    wait_rows_ne(4'b1101, 40, "release_leaves_row1");
    chk("resume_row2", 32'(rows), 32'hB);
    cyc(20);
    chk("drain_clean", 32'(exp_q.size()), 32'd0);

    // Two presses: (0,0) then (3,1).
    expect_key(0);
    pressed[0] = 1'b1; cyc(40); pressed[0] = 1'b0; cyc(30);
    expect_key(13);
    pressed[13] = 1'b1; cyc(40); pressed[13] = 1'b0; cyc(30);
    chk("pair_new", 32'(new_digit), 32'h0);
    chk("pair_old", 32'(old_digit), 32'h1);
    chk("drain_pair", 32'(exp_q.size()), 32'd0);

    // Press bounce on (2,0), aligned to the start of the row-2 window.
    wait_rows_ne(4'b1011, 20, "align_bounce_a");
    wait_rows_eq(4'b1011, 20, "align_bounce_b");
    p0 = pulses;
    pressed[8] = 1'b1; cyc(5);
    pressed[8] = 1'b0; cyc(1);
    chk("bounce_no_early_pulse", 32'(pulses), 32'(p0));
    expect_key(8);
    t_final = $time;
    pressed[8] = 1'b1; cyc(40);
    pressed[8] = 1'b0; cyc(30);
    chk("bounce_one_pulse", 32'(pulses - p0), 32'd1);
    chk("bounce_delay_min", 32'((last_pulse_t - t_final) >= DEB * 10), 32'd1);
    chk("bounce_delay_max", 32'((last_pulse_t - t_final) <= (4 * SD + DEB + 6) * 10), 32'd1);

    // Hold (1,0), add (1,3) and (2,1): no extra events.
    p0 = pulses;
    expect_key(4);
    pressed[4] = 1'b1; cyc(40);
    pressed[7] = 1'b1; pressed[9] = 1'b1; cyc(30);
    pressed = 16'h0; cyc(30);
    chk("rollover_one_pulse", 32'(pulses - p0), 32'd1);
    // Same-row pair from idle: lowest column.
    expect_key(4);
    pressed[4] = 1'b1; pressed[7] = 1'b1; cyc(40);
    pressed = 16'h0; cyc(30);
    // Different rows, row 0 scanned first.
    wait_rows_ne(4'b1110, 20, "align_rows_a");
    wait_rows_eq(4'b1110, 20, "align_rows_b");
    expect_key(1);
    pressed[1] = 1'b1; pressed[10] = 1'b1; cyc(40);
    pressed = 16'h0; cyc(30);
    chk("drain_multi", 32'(exp_q.size()), 32'd0);

    // Random presses with an optional short release glitch while held.
    for (int i = 0; i < 8; i++) begin
      int k, hold, g, rel;
      k    = int'($urandom_range(15, 0));
      hold = int'($urandom_range(70, 45));
      g    = int'($urandom_range(5, 0));
      rel  = int'($urandom_range(40, 25));
      p0   = pulses;
      expect_key(k);
      pressed[k] = 1'b1; cyc(35);
      if (g > 0) begin
        pressed[k] = 1'b0; cyc(g); pressed[k] = 1'b1;
      end
      cyc(hold - 35);
      pressed[k] = 1'b0; cyc(rel);
      chk("rand_one_pulse", 32'(pulses - p0), 32'd1);
    end
    chk("drain_rand", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of the press debounce of (0,3).
    wait_rows_ne(4'b1110, 20, "align_rst_a");
    wait_rows_eq(4'b1110, 20, "align_rst_b");
    pressed[3] = 1'b1;
    cyc(SD + 2);
    reset = 1'b0;
    #1;
    chk("midrst_kv", 32'(key_valid), 32'd0);
    chk("midrst_code", 32'(key_code), 32'd0);
    chk("midrst_new", 32'(new_digit), 32'd0);
    chk("midrst_old", 32'(old_digit), 32'd0);
    chk("midrst_rows", 32'(rows), 32'hE);
    model_new = 4'h0;
    cyc(3);
    reset = 1'b1;
    p0 = pulses;
    cyc(4);
    chk("no_pulse_on_rst_release", 32'(pulses), 32'(p0));
    expect_key(3);
    cyc(40);
    pressed[3] = 1'b0; cyc(30);
    chk("rst_fresh_pulse", 32'(pulses - p0), 32'd1);
    chk("final_new", 32'(new_digit), 32'(model_new));
    chk("drain_final", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
